// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: round-robin N:1 arbiter/sequencer driving a shared mux onto a valid/ready output
// Ports: clk, rst (sync, active-high); req[N] and in_data[N*DATA_W] from the requesters;
// gnt one-hot transfer ack; sel registered mux select; out_valid/out_data/out_ready to the sink;
// busy high while a word is being offered.
module rr_mux_arbiter #(
    parameter  int N      = 16,
    parameter  int DATA_W = 8,
    localparam int SEL_W  = N > 1 ? $clog2(N) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N-1:0]        req,
    input  logic [N*DATA_W-1:0] in_data,
    output logic [N-1:0]        gnt,
    output logic [SEL_W-1:0]    sel,
    output logic                out_valid,
    output logic [DATA_W-1:0]   out_data,
    input  logic                out_ready,
    output logic                busy
);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t             state, state_nx;
    logic [SEL_W-1:0]   ptr, ptr_nx, sel_nx, ptr_inc, start, win;
    logic [N-1:0]       sel_oh, cand;
    logic               hs, adv, found;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sel   <= '0;
            ptr   <= '0;
        end else begin
            state <= state_nx;
            sel   <= sel_nx;
            ptr   <= ptr_nx;
        end
    end
    // After a handshake the search restarts just past the finished owner and
    // excludes it, so the owner cannot win twice in a row.
    always_comb begin
        sel_oh  = N'(1) << sel;
        hs      = state == GRANT && out_ready;
        ptr_inc = sel == SEL_W'(N - 1) ? '0 : sel + 1'b1;
        start   = hs ? ptr_inc : ptr;
        cand    = hs ? req & ~sel_oh : req;
        found   = 1'b0;
        win     = '0;
        for (int i = 0; i < N; i++) begin
            if (!found && cand[(int'(start) + i) % N]) begin
                found = 1'b1;
                win   = SEL_W'((int'(start) + i) % N);
            end
        end
        adv      = state == IDLE || hs;
        state_nx = adv ? (found ? GRANT : IDLE) : state;
        sel_nx   = adv && found ? win : sel;
        ptr_nx   = hs ? ptr_inc : ptr;
    end
    assign out_valid = state == GRANT;
    assign busy      = out_valid;
    assign gnt       = hs ? sel_oh : '0;
    assign out_data  = in_data[int'(sel)*DATA_W +: DATA_W];
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb_rr_mux_arbiter: directed table-driven bench for rr_mux_arbiter
module tb_rr_mux_arbiter;
    logic         clk = 1'b0;
    logic         rst;
    logic [15:0]  req;
    logic [127:0] in_data;
    logic [15:0]  gnt;
    logic [3:0]   sel;
    logic         out_valid;
    logic [7:0]   out_data;
    logic         out_ready;
    logic         busy;
    int checks = 0;
    int errors = 0;
    typedef struct {
        logic        rst;
        logic [15:0] req;
        logic        rdy;
        logic        v;
        logic [3:0]  s;
        logic [15:0] g;
        logic        b;
        logic [7:0]  d;
    } vec_t;
    vec_t tbl[$];
    rr_mux_arbiter #(.N(16), .DATA_W(8)) dut (
        .clk(clk), .rst(rst), .req(req), .in_data(in_data), .gnt(gnt), .sel(sel),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .busy(busy)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        rst = 1'b0;
    endtask
    initial begin
        rst = 1'b1;
        req = '0;
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) in_data[i*8 +: 8] = 8'hA0 + 8'(i);
        // rst, req, rdy | valid, sel, gnt, busy, data
        tbl.push_back('{1'b0, 16'h0000, 1'b1, 1'b0, 4'd0,  16'h0000, 1'b0, 8'hA0});
        tbl.push_back('{1'b0, 16'h0020, 1'b1, 1'b0, 4'd0,  16'h0000, 1'b0, 8'hA0});
        tbl.push_back('{1'b0, 16'h0020, 1'b1, 1'b1, 4'd5,  16'h0020, 1'b1, 8'hA5});
        tbl.push_back('{1'b0, 16'h0000, 1'b1, 1'b0, 4'd5,  16'h0000, 1'b0, 8'hA5});
        tbl.push_back('{1'b0, 16'hFFFF, 1'b0, 1'b0, 4'd5,  16'h0000, 1'b0, 8'hA5});
        tbl.push_back('{1'b0, 16'hFFFF, 1'b0, 1'b1, 4'd6,  16'h0000, 1'b1, 8'hA6});
        tbl.push_back('{1'b0, 16'h0040, 1'b1, 1'b1, 4'd6,  16'h0040, 1'b1, 8'hA6});
        tbl.push_back('{1'b0, 16'h0008, 1'b0, 1'b0, 4'd6,  16'h0000, 1'b0, 8'hA6});
        tbl.push_back('{1'b0, 16'h0008, 1'b0, 1'b1, 4'd3,  16'h0000, 1'b1, 8'hA3});
        tbl.push_back('{1'b0, 16'h0009, 1'b0, 1'b1, 4'd3,  16'h0000, 1'b1, 8'hA3});
        tbl.push_back('{1'b0, 16'h0009, 1'b0, 1'b1, 4'd3,  16'h0000, 1'b1, 8'hA3});
        tbl.push_back('{1'b0, 16'h0009, 1'b0, 1'b1, 4'd3,  16'h0000, 1'b1, 8'hA3});
        tbl.push_back('{1'b0, 16'h0009, 1'b0, 1'b1, 4'd3,  16'h0000, 1'b1, 8'hA3});
        tbl.push_back('{1'b0, 16'h0009, 1'b1, 1'b1, 4'd3,  16'h0008, 1'b1, 8'hA3});
        tbl.push_back('{1'b0, 16'h0001, 1'b1, 1'b1, 4'd0,  16'h0001, 1'b1, 8'hA0});
        tbl.push_back('{1'b0, 16'h0000, 1'b1, 1'b0, 4'd0,  16'h0000, 1'b0, 8'hA0});
        tbl.push_back('{1'b0, 16'h4000, 1'b1, 1'b0, 4'd0,  16'h0000, 1'b0, 8'hA0});
        tbl.push_back('{1'b0, 16'h4000, 1'b1, 1'b1, 4'd14, 16'h4000, 1'b1, 8'hAE});
        tbl.push_back('{1'b0, 16'h8001, 1'b1, 1'b0, 4'd14, 16'h0000, 1'b0, 8'hAE});
        tbl.push_back('{1'b0, 16'h8001, 1'b1, 1'b1, 4'd15, 16'h8000, 1'b1, 8'hAF});
        tbl.push_back('{1'b0, 16'h0001, 1'b1, 1'b1, 4'd0,  16'h0001, 1'b1, 8'hA0});
        tbl.push_back('{1'b0, 16'hFFFF, 1'b0, 1'b0, 4'd0,  16'h0000, 1'b0, 8'hA0});
        tbl.push_back('{1'b0, 16'hFFFF, 1'b0, 1'b1, 4'd1,  16'h0000, 1'b1, 8'hA1});
        tbl.push_back('{1'b1, 16'hFFFF, 1'b0, 1'b1, 4'd1,  16'h0000, 1'b1, 8'hA1});
        tbl.push_back('{1'b0, 16'h0000, 1'b1, 1'b0, 4'd0,  16'h0000, 1'b0, 8'hA0});
        tbl.push_back('{1'b0, 16'h0004, 1'b0, 1'b0, 4'd0,  16'h0000, 1'b0, 8'hA0});
        tbl.push_back('{1'b0, 16'h0000, 1'b0, 1'b1, 4'd2,  16'h0000, 1'b1, 8'hA2});
        tbl.push_back('{1'b0, 16'h0000, 1'b1, 1'b1, 4'd2,  16'h0004, 1'b1, 8'hA2});
        tbl.push_back('{1'b0, 16'h0000, 1'b1, 1'b0, 4'd2,  16'h0000, 1'b0, 8'hA2});
        repeat (2) @(posedge clk);
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            rst = tbl[i].rst;
            req = tbl[i].req;
            out_ready = tbl[i].rdy;
            #1;
            chk($sformatf("row%0d valid", i), 32'(out_valid), 32'(tbl[i].v));
            chk($sformatf("row%0d sel", i), 32'(sel), 32'(tbl[i].s));
            chk($sformatf("row%0d gnt", i), 32'(gnt), 32'(tbl[i].g));
            chk($sformatf("row%0d busy", i), 32'(busy), 32'(tbl[i].b));
            chk($sformatf("row%0d data", i), 32'(out_data), 32'(tbl[i].d));
        end
        // all requesting from reset: strict rotation, one word per cycle
        do_reset();
        @(negedge clk);
        req = 16'hFFFF;
        out_ready = 1'b1;
        #1;
        chk("all idle valid", 32'(out_valid), 32'd0);
        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("all%0d sel", k), 32'(sel), 32'(k % 16));
            chk($sformatf("all%0d gnt", k), 32'(gnt), 32'(1) << (k % 16));
            chk($sformatf("all%0d valid", k), 32'(out_valid), 32'd1);
            chk($sformatf("all%0d data", k), 32'(out_data), 32'(8'hA0 + 8'(k % 16)));
        end
        // select sweep with slice i = i
        do_reset();
        for (int i = 0; i < 16; i++) in_data[i*8 +: 8] = 8'(i);
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            req = 16'(32'(1) << i);
            @(negedge clk);
            #1;
            chk($sformatf("sweep%0d sel", i), 32'(sel), 32'(i));
            chk($sformatf("sweep%0d data", i), 32'(out_data), 32'(i));
            chk($sformatf("sweep%0d gnt", i), 32'(gnt), 32'(1) << i);
            req = '0;
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
